// File: rtl/blk_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// blk_mem_responder_pkg
// Shared definitions for the block memory responder: block geometry, FSM
// state encoding, operation codes and a small address helper.
// -----------------------------------------------------------------------------
package blk_mem_responder_pkg;

    // One cache block is 256 bits = 32 bytes, so 5 byte-offset bits.
    localparam int BLOCK_W  = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Block number of a byte address (byte offset within the block dropped).
    function automatic logic [31:0] blk_number(input logic [31:0] addr);
        return {{OFFSET_W{1'b0}}, addr[31:OFFSET_W]};
    endfunction

endpackage

// File: rtl/blk_mem_array.sv
// -----------------------------------------------------------------------------
// blk_mem_array
// 2^IDX_W x 256-bit synchronous single-port block storage. No reset: the
// contents survive RESET of the responder.
// Ports:
//   clk    in   clock
//   we     in   write enable (wdata -> mem[idx] on the rising edge)
//   re     in   read enable (mem[idx] -> rdata on the rising edge)
//   idx    in   block index
//   wdata  in   write data
//   rdata  out  registered read data, holds its value until the next read
// -----------------------------------------------------------------------------
module blk_mem_array
    import blk_mem_responder_pkg::*;
#(
    parameter int IDX_W = 10
)
(
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [IDX_W-1:0]   idx,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata
);

    logic [BLOCK_W-1:0] r_mem [0:(2**IDX_W)-1];

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[idx];
        end
    end

endmodule

// File: rtl/blk_mem_responder.sv
// -----------------------------------------------------------------------------
// blk_mem_responder
// Main-memory model for the 256-bit cache block protocol. Accepts one block
// read or block write at a time from IDLE and answers it with a one-cycle
// valid pulse exactly LATENCY cycles after the accepting cycle.
// Ports:
//   CLK                in   clock, rising edge
//   RESET              in   synchronous active-high reset
//   blk_addr           in   byte address of the block, [4:0] ignored
//   blk_read           in   block read request (level)
//   blk_write          in   block write request (level, wins over read)
//   block_write        in   write data, sampled at acceptance
//   block_read         out  read data, held until the next read response
//   block_read_valid   out  one-cycle pulse: read complete
//   block_write_valid  out  one-cycle pulse: write committed
//   busy               out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module blk_mem_responder
    import blk_mem_responder_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10
)
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        blk_addr,
    input  logic               blk_read,
    input  logic               blk_write,
    input  logic [BLOCK_W-1:0] block_write,
    output logic [BLOCK_W-1:0] block_read,
    output logic               block_read_valid,
    output logic               block_write_valid,
    output logic               busy
);

    // With LATENCY==1 the accept edge is also the edge entering RESP.
    localparam logic       LAT_ONE  = (LATENCY == 32'sd1);
    localparam int         LAT_M2   = (LATENCY > 32'sd1) ? (LATENCY - 32'sd2) : 32'sd0;
    localparam logic [7:0] CNT_INIT = LAT_M2[7:0];

    state_e             r_state;
    op_e                r_op;
    logic [7:0]         r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [BLOCK_W-1:0] r_wdata;
    logic               r_rd_valid;
    logic               r_wr_valid;
    logic               r_busy;
    logic               r_rd_have;

    logic [31:0]        w_blk_num;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_unused_blk_upper;
    op_e                w_new_op;
    op_e                w_resp_op;
    logic               w_idle_accept;
    logic               w_enter_resp;
    logic [IDX_W-1:0]   w_ram_idx;
    logic [BLOCK_W-1:0] w_ram_wdata;
    logic               w_ram_we;
    logic               w_ram_re;
    logic [BLOCK_W-1:0] w_ram_rdata;

    // Upper block-number bits wrap away: addresses alias modulo 2^IDX_W blocks.
    assign w_blk_num          = blk_number(blk_addr);
    assign w_req_idx          = w_blk_num[IDX_W-1:0];
    assign w_unused_blk_upper = ^w_blk_num[31:IDX_W];

    // Acceptance, RESP entry and RAM port steering. In IDLE the RAM sees the
    // live request so a LATENCY==1 transaction can commit on its accept edge.
    always_comb begin
        w_new_op      = blk_write ? OP_WR : OP_RD;
        w_idle_accept = 1'b0;
        w_enter_resp  = 1'b0;
        w_resp_op     = r_op;
        w_ram_idx     = r_idx;
        w_ram_wdata   = r_wdata;
        case (r_state)
            ST_IDLE: begin
                w_idle_accept = blk_write | blk_read;
                w_enter_resp  = w_idle_accept & LAT_ONE;
                w_resp_op     = w_new_op;
                w_ram_idx     = w_req_idx;
                w_ram_wdata   = block_write;
            end
            ST_WAIT: begin
                w_enter_resp = (r_cnt == 8'd0);
            end
            default: begin
                w_enter_resp = 1'b0;
            end
        endcase
    end

    // RESET gates the RAM so an aborted write never reaches the array.
    assign w_ram_we = ~RESET & w_enter_resp & (w_resp_op == OP_WR);
    assign w_ram_re = ~RESET & w_enter_resp & (w_resp_op == OP_RD);

    blk_mem_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (CLK),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .idx   (w_ram_idx),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    // Transaction FSM with latency counter, capture registers and outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_RD;
            r_cnt      <= 8'd0;
            r_idx      <= {IDX_W{1'b0}};
            r_wdata    <= {BLOCK_W{1'b0}};
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_have  <= 1'b0;
        end else begin
            r_wr_valid <= w_enter_resp & (w_resp_op == OP_WR);
            r_rd_valid <= w_enter_resp & (w_resp_op == OP_RD);
            if (w_ram_re) begin
                r_rd_have <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_accept) begin
                        r_op    <= w_new_op;
                        r_idx   <= w_req_idx;
                        r_wdata <= block_write;
                        r_busy  <= 1'b1;
                        if (LAT_ONE) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is the RAM output register itself; it only reloads on a
    // read response, and reads as zero until the first one after reset.
    assign block_read        = r_rd_have ? w_ram_rdata : {BLOCK_W{1'b0}};
    assign block_read_valid  = r_rd_valid;
    assign block_write_valid = r_wr_valid;
    assign busy              = r_busy;

endmodule

// File: doc/blk_mem_responder.md
Name: blk_mem_responder

Overview:
- Memory-side responder for the 256-bit cache block protocol: answers block read (iBlkRead/dBlkRead) and block write (dBlkWrite) requests from the IC/DC with a fixed, configurable latency.
- Backed by an internal block-organised storage array.
- Sits outside the MIPS top as the simulation main-memory model feeding block_read_f*/block_*_valid.
- Lets cache controllers be verified against a cycle-accurate, deterministic memory.

Parameters:
- LATENCY, 4, cycles from request acceptance to the valid pulse; legal range 1..255.
- IDX_W, 10, log2 of the number of 32-byte blocks stored; default is 1024 blocks = 32 KB.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- blk_addr  in  32  byte address of the block; bits [4:0] ignored.
- blk_read  in  1  block read request, level, held by the requester.
- blk_write  in  1  block write request, level, held by the requester.
- block_write  in  256  write data; sampled at acceptance.
- block_read  out  256  read data; valid while block_read_valid=1, held until the next read response.
- block_read_valid  out  1  one-cycle pulse: read complete.
- block_write_valid  out  1  one-cycle pulse: write committed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET).
- Reset values: state=IDLE, block_read=0, both valid outputs=0, busy=0, latency counter=0. Storage array contents are not cleared.
- Index = blk_addr[5+IDX_W-1:5]. Higher address bits are ignored, so addresses wrap modulo 2^IDX_W blocks.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If blk_write=1, accept a write: capture index and block_write, op=WR.
  - Else if blk_read=1, accept a read: capture index, op=RD.
  - Write has priority when both are high (dirty eviction before refill). The read stays asserted and is accepted after the write's RESP.
  - On accept: go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY-2.
- WAIT: decrement the counter. At 0, go to RESP.
- Storage update: on the edge entering RESP,
  - WR: array[idx] <= captured data.
  - RD: block_read <= array[idx].
- RESP: assert block_write_valid (WR) or block_read_valid (RD) for exactly this cycle, then go to IDLE.
- Latency: a request high in accepting cycle c produces its valid pulse in cycle c+LATENCY.
- Handshake:
  - The requester must deassert in the cycle after the valid pulse.
  - A request still high in IDLE is accepted as a new transaction; back-to-back transactions are legal, with one IDLE cycle between them.
- Request changes after acceptance are ignored, including blk_addr, block_write, and dropping the request. The transaction completes and its valid still pulses.
- Read-after-write to the same block: a read accepted after the write's RESP returns the new data.
- RESET mid-operation: abort immediately. An uncommitted write is discarded and the array is unchanged. Outputs return to reset values on the next cycle.
- Valid outputs are never both high. busy=0 only in IDLE.

Decomposition:
- Shared include (alongside config.v):
  - BLOCK_W=256, OFFSET_W=5.
  - State encodings ST_IDLE/ST_WAIT/ST_RESP (2 bits).
  - Op codes OP_RD/OP_WR.
- Sub-module blk_mem_array: 2^IDX_W x 256 synchronous single-port RAM.
  - Ports: we, idx, wdata, rdata (registered), no reset.
- Top holds the FSM, latency counter and capture registers.

Test Plan:
- Reset then write: RESET 2 cycles, then blk_write=1, addr=0x0000_0040, data=256'hA5..A5 at cycle 0 (LATENCY=4) -> block_write_valid=1 in cycle 4 only; busy=1 cycles 1-4.
- Read-back: blk_read=1, addr=0x0000_005F (same block, offset ignored) -> block_read_valid in cycle 4 with block_read=256'hA5..A5; block_read stays stable afterwards.
- Simultaneous read+write: both high, write data=256'h1234, addr=0x80 -> write_valid at cycle 4, then read accepted at cycle 5 and read_valid at cycle 9 returning 256'h1234.
- Wrap: IDX_W=10, write addr=0x0000_8000 data=256'h7 -> read addr=0x0 returns 256'h7.
- Mid-op changes: after accept, drop blk_read at cycle 1 and change blk_addr -> read_valid still pulses at cycle 4 with the originally addressed data. Separately, with LATENCY=1 -> valid in cycle 1.
- Reset mid-write: write to 0x100 with data=256'hFF, RESET at cycle 2 -> no write_valid; a subsequent read of 0x100 returns the prior contents.
